// File: rtl/lcd_hex_driver.sv
// HD44780 8-bit write-only driver: power-up init, then shows a latched 32-bit word as hex on line 1, col 0.
// Optional "0x" prefix before the digits when LCD_HEX_PREFIX_EN is defined.
module lcd_hex_driver #(
    parameter int PWRUP_CYC    = 750000,
    parameter int SETUP_CYC    = 4,
    parameter int EN_CYC       = 12,
    parameter int CMD_WAIT_CYC = 2500,
    parameter int CLR_WAIT_CYC = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Msg,
    input  logic        msg_load,
    output logic        busy,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_EN
);

    localparam int MAX_A = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
    localparam int MAX_B = (CMD_WAIT_CYC > EN_CYC) ? CMD_WAIT_CYC : EN_CYC;
    localparam int MAX_C = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
    localparam int MAXP  = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int CNT_W = $clog2(MAXP + 1);

    localparam logic [CNT_W-1:0] PWRUP_LIM = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LIM = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LIM    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LIM   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LIM   = CNT_W'(CLR_WAIT_CYC - 1);

    localparam logic [1:0] S_PWRUP   = 2'd0;
    localparam logic [1:0] S_INIT    = 2'd1;
    localparam logic [1:0] S_REFRESH = 2'd2;
    localparam logic [1:0] S_IDLE    = 2'd3;

    localparam logic [1:0] X_NONE  = 2'd0;
    localparam logic [1:0] X_SETUP = 2'd1;
    localparam logic [1:0] X_PULSE = 2'd2;
    localparam logic [1:0] X_WAIT  = 2'd3;

`ifdef LCD_HEX_PREFIX_EN
    localparam logic [3:0] LAST_STEP = 4'd10;
`else
    localparam logic [3:0] LAST_STEP = 4'd8;
`endif

    // Returns {rs, data} for a given step; REFRESH step 0 is the DDRAM address command.
    function automatic logic [8:0] xfer_byte(input logic [1:0] st, input logic [3:0] step,
                                             input logic [31:0] word);
        logic [2:0] idx;
        logic [3:0] nib;
        idx       = 3'd0;
        nib       = 4'd0;
        xfer_byte = 9'h000;
        if (st == S_INIT) begin
            case (step)
                4'd0:    xfer_byte = {1'b0, 8'h38};
                4'd1:    xfer_byte = {1'b0, 8'h0C};
                4'd2:    xfer_byte = {1'b0, 8'h01};
                default: xfer_byte = {1'b0, 8'h06};
            endcase
        end else if (step == 4'd0) begin
            xfer_byte = {1'b0, 8'h80};
        end else begin
`ifdef LCD_HEX_PREFIX_EN
            if (step == 4'd1) begin
                xfer_byte = {1'b1, 8'h30};
            end else if (step == 4'd2) begin
                xfer_byte = {1'b1, 8'h78};
            end else begin
                idx       = 3'(step - 4'd3);
                nib       = word[5'd28 - {idx, 2'b00} +: 4];
                xfer_byte = {1'b1, (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib})};
            end
`else
            idx       = 3'(step - 4'd1);
            nib       = word[5'd28 - {idx, 2'b00} +: 4];
            xfer_byte = {1'b1, (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib})};
`endif
        end
    endfunction

    logic [1:0]       state_q, state_d;
    logic [1:0]       xfer_q, xfer_d;
    logic [3:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      snapshot_q, snapshot_d;
    logic [31:0]      work_q, work_d;
    logic             pending_q, pending_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic             start;
    logic [CNT_W-1:0] wait_lim;

    always_comb begin
        state_d    = state_q;
        xfer_d     = xfer_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        snapshot_d = snapshot_q;
        work_d     = work_q;
        pending_d  = pending_q;
        data_d     = data_q;
        rs_d       = rs_q;
        en_d       = en_q;
        start      = 1'b0;
        wait_lim   = (!rs_q && data_q == 8'h01) ? CLR_LIM : CMD_LIM;

        if (msg_load) begin
            snapshot_d = Msg;
            pending_d  = 1'b1;
        end

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWRUP_LIM) begin
                    state_d = S_INIT;
                    step_d  = 4'd0;
                    start   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (pending_q || msg_load) begin
                    state_d = S_REFRESH;
                    step_d  = 4'd0;
                    start   = 1'b1;
                end
            end
            default: begin
                case (xfer_q)
                    X_SETUP: begin
                        if (cnt_q == SETUP_LIM) begin
                            xfer_d = X_PULSE;
                            cnt_d  = '0;
                            en_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    X_PULSE: begin
                        if (cnt_q == EN_LIM) begin
                            xfer_d = X_WAIT;
                            cnt_d  = '0;
                            en_d   = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    X_WAIT: begin
                        if (cnt_q != wait_lim) begin
                            cnt_d = cnt_q + 1'b1;
                        end else if (state_q == S_INIT && step_q == 4'd3) begin
                            state_d = S_REFRESH;
                            step_d  = 4'd0;
                            start   = 1'b1;
                        end else if (state_q == S_REFRESH && step_q == LAST_STEP) begin
                            state_d = S_IDLE;
                            xfer_d  = X_NONE;
                            cnt_d   = '0;
                        end else begin
                            step_d = step_q + 4'd1;
                            start  = 1'b1;
                        end
                    end
                    default: xfer_d = X_NONE;
                endcase
            end
        endcase

        // A load in the entry cycle is shown by this refresh, so it leaves nothing pending.
        if (start && state_d == S_REFRESH && step_d == 4'd0) begin
            work_d    = msg_load ? Msg : snapshot_q;
            pending_d = 1'b0;
        end

        if (start) begin
            xfer_d         = X_SETUP;
            cnt_d          = '0;
            {rs_d, data_d} = xfer_byte(state_d, step_d, work_d);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_PWRUP;
            xfer_q     <= X_NONE;
            step_q     <= 4'd0;
            cnt_q      <= '0;
            snapshot_q <= 32'h0;
            work_q     <= 32'h0;
            pending_q  <= 1'b0;
            data_q     <= 8'h00;
            rs_q       <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            xfer_q     <= xfer_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            snapshot_q <= snapshot_d;
            work_q     <= work_d;
            pending_q  <= pending_d;
            data_q     <= data_d;
            rs_q       <= rs_d;
            en_q       <= en_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign LCD_DATA = data_q;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;
    assign LCD_EN   = en_q;

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Scoreboard bench for lcd_hex_driver: expected LCD transfers are queued by the stimulus,
// a negedge monitor pops and compares on every LCD_EN rise and checks pulse/gap/busy timing.
module tb_lcd_hex_driver;

    localparam int PWRUP_CYC    = 20;
    localparam int SETUP_CYC    = 2;
    localparam int EN_CYC       = 3;
    localparam int CMD_WAIT_CYC = 5;
    localparam int CLR_WAIT_CYC = 10;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] Msg = 32'h0;
    logic        msg_load = 1'b0;
    logic        busy;
    logic [7:0]  LCD_DATA;
    logic        LCD_RS;
    logic        LCD_RW;
    logic        LCD_EN;

    lcd_hex_driver #(
        .PWRUP_CYC   (PWRUP_CYC),
        .SETUP_CYC   (SETUP_CYC),
        .EN_CYC      (EN_CYC),
        .CMD_WAIT_CYC(CMD_WAIT_CYC),
        .CLR_WAIT_CYC(CLR_WAIT_CYC)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Msg     (Msg),
        .msg_load(msg_load),
        .busy    (busy),
        .LCD_DATA(LCD_DATA),
        .LCD_RS  (LCD_RS),
        .LCD_RW  (LCD_RW),
        .LCD_EN  (LCD_EN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int b;
        int gap;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic push(input int b, input int gap);
        exp_t e;
        e.b   = b;
        e.gap = gap;
        q.push_back(e);
    endtask

    // Reference: command bytes and the printable hex text of the word.
    task automatic push_init();
        push(9'h038, 0);
        push(9'h00C, SETUP_CYC + CMD_WAIT_CYC);
        push(9'h001, SETUP_CYC + CMD_WAIT_CYC);
        push(9'h006, SETUP_CYC + CLR_WAIT_CYC);
    endtask

    task automatic push_refresh(input logic [31:0] v, input int first_gap);
        logic [31:0] t;
        int          nib;
        int          ch;
        push(9'h080, first_gap);
`ifdef LCD_HEX_PREFIX_EN
        push(256 + 48, SETUP_CYC + CMD_WAIT_CYC);
        push(256 + 120, SETUP_CYC + CMD_WAIT_CYC);
`endif
        for (int i = 7; i >= 0; i--) begin
            t   = v >> (4 * i);
            nib = int'(t & 32'hF);
            ch  = (nib < 10) ? (48 + nib) : (65 + nib - 10);
            push(256 + ch, SETUP_CYC + CMD_WAIT_CYC);
        end
    endtask

    task automatic load(input logic [31:0] v);
        @(negedge CLK);
        Msg      = v;
        msg_load = 1'b1;
        @(negedge CLK);
        msg_load = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int quiet;
        int n;
        quiet = 0;
        n     = 0;
        while (quiet < 3 && n < bound) begin
            @(negedge CLK);
            quiet = busy ? 0 : quiet + 1;
            n++;
        end
        if (quiet < 3) begin
            checks++;
            failures++;
            $display("FAIL wait_idle timeout busy=%0b after %0d cycles", busy, n);
        end
    endtask

    // Monitor
    initial begin
        logic prev_en;
        logic prev_busy;
        int   hi_cnt;
        int   low_cnt;
        logic have_fall;
        exp_t e;
        prev_en   = 1'b0;
        prev_busy = 1'b1;
        hi_cnt    = 0;
        low_cnt   = 0;
        have_fall = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_en   = 1'b0;
                prev_busy = 1'b1;
                hi_cnt    = 0;
                low_cnt   = 0;
                have_fall = 1'b0;
            end else begin
                if (LCD_EN && !prev_en) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_xfer actual=%03h required=none at %0t",
                                 {LCD_RS, LCD_DATA}, $time);
                    end else begin
                        e = q.pop_front();
                        chk("xfer_byte", int'({LCD_RS, LCD_DATA}), e.b);
                        if (e.gap != 0 && have_fall) chk("en_gap", low_cnt, e.gap);
                    end
                    hi_cnt = 1;
                end else if (LCD_EN) begin
                    hi_cnt++;
                end else if (prev_en) begin
                    chk("en_width", hi_cnt, EN_CYC);
                    low_cnt   = 1;
                    have_fall = 1'b1;
                end else begin
                    low_cnt++;
                end
                if (prev_busy && !busy && have_fall) chk("busy_fall", low_cnt, CMD_WAIT_CYC + 1);
                prev_en   = LCD_EN;
                prev_busy = busy;
            end
        end
    end

    // Stimulus
    initial begin
        logic [31:0] v;
        int          n;

        repeat (3) @(negedge CLK);
        chk("rst_data", int'(LCD_DATA), 0);
        chk("rst_rs", int'(LCD_RS), 0);
        chk("rst_rw", int'(LCD_RW), 0);
        chk("rst_en", int'(LCD_EN), 0);
        chk("rst_busy", int'(busy), 1);

        push_init();
        push_refresh(32'h0, SETUP_CYC + CMD_WAIT_CYC);
        RST = 1'b0;
        wait_idle(2000);

        load(32'hDEADBEEF);
        chk("busy_rise", int'(busy), 1);
        push_refresh(32'hDEADBEEF, 0);

        // Two loads during one refresh coalesce into a single follow-up refresh.
        repeat (30) @(negedge CLK);
        load(32'h12345678);
        chk("busy_mid1", int'(busy), 1);
        repeat (20) @(negedge CLK);
        load(32'h0000000F);
        chk("busy_mid2", int'(busy), 1);
        push_refresh(32'h0000000F, 0);
        wait_idle(3000);
        repeat (20) @(negedge CLK);
        chk("coalesce_drained", q.size(), 0);

        load(32'h000000A5);
        push_refresh(32'h000000A5, 0);
        wait_idle(2000);

        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            load(v);
            push_refresh(v, 0);
            wait_idle(2000);
        end

        // Reset while a character strobe is high.
        v = $urandom;
        load(v);
        push_refresh(v, 0);
        n = 0;
        while (!(LCD_EN && LCD_RS) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("en_char_seen", int'(LCD_EN && LCD_RS), 1);
        #1 RST = 1'b1;
        #1;
        chk("arst_en", int'(LCD_EN), 0);
        chk("arst_busy", int'(busy), 1);
        chk("arst_data", int'(LCD_DATA), 0);
        q.delete();
        repeat (3) @(negedge CLK);
        push_init();
        push_refresh(32'h0, SETUP_CYC + CMD_WAIT_CYC);
        RST = 1'b0;
        wait_idle(2000);

        repeat (30) @(negedge CLK);
        chk("final_drained", q.size(), 0);
        chk("final_idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
